// File: rtl/blockram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the blockram FIFO controller and its output buffer.
package blockram_fifo_ctrl_pkg;

    localparam int BYTE_LEN_IN_BITS = 8;

    // RAM address width for a power-of-2 FIFO depth; the pointers carry one extra wrap bit.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/blockram_fifo_ctrl_output_buf.sv
// Two-entry output buffer that hides the blockram read latency; entry 0 is the FIFO head.
module fifo_output_skid_buffer
    import blockram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  cap_valid_in,
    input  logic [DATA_WIDTH-1:0] cap_data_in,
    input  logic                  deq_ready_in,
    output logic                  deq_valid_out,
    output logic [DATA_WIDTH-1:0] deq_data_out,
    output logic                  deq_fire_out,
    output logic [1:0]            ob_cnt_out
);

    logic [DATA_WIDTH-1:0] r_ob0;
    logic [DATA_WIDTH-1:0] r_ob1;
    logic [1:0]            r_ob_cnt;
    logic [1:0]            w_base;
    logic                  w_deq_fire;

    assign deq_valid_out = (r_ob_cnt != 2'd0);
    assign deq_data_out  = r_ob0;
    assign w_deq_fire    = deq_valid_out & deq_ready_in;
    assign deq_fire_out  = w_deq_fire;
    assign ob_cnt_out    = r_ob_cnt;

    // Slot the captured word lands in once this cycle's dequeue shift is applied.
    assign w_base = r_ob_cnt - {1'b0, w_deq_fire};

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_ob0    <= '0;
            r_ob1    <= '0;
            r_ob_cnt <= 2'd0;
        end else begin
            if (w_deq_fire) begin
                r_ob0 <= r_ob1;
            end
            // Later assignment wins, so a capture into slot 0 overrides the shift.
            if (cap_valid_in) begin
                if (w_base == 2'd0) begin
                    r_ob0 <= cap_data_in;
                end else begin
                    r_ob1 <= cap_data_in;
                end
            end
            r_ob_cnt <= w_base + {1'b0, cap_valid_in};
        end
    end

endmodule

// File: rtl/blockram_fifo_ctrl.sv
// FIFO controller owning the pointers of a dual-port read-first blockram (1-cycle read
// latency) with a 2-entry output buffer; capacity is DEPTH + 2 words.
module blockram_fifo_ctrl
    import blockram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int DEPTH          = 64,
    parameter int PTR_WIDTH      = fifo_ptr_width(DEPTH),
    parameter int WRITE_MASK_LEN = DATA_WIDTH / BYTE_LEN_IN_BITS
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      enq_valid_in,
    input  logic [DATA_WIDTH-1:0]     enq_data_in,
    output logic                      enq_ready_out,
    output logic                      deq_valid_out,
    output logic [DATA_WIDTH-1:0]     deq_data_out,
    input  logic                      deq_ready_in,
    output logic                      ram_write_access_en_out,
    output logic [WRITE_MASK_LEN-1:0] ram_write_en_out,
    output logic [PTR_WIDTH-1:0]      ram_write_set_addr_out,
    output logic [DATA_WIDTH-1:0]     ram_write_data_out,
    output logic                      ram_read_access_en_out,
    output logic [PTR_WIDTH-1:0]      ram_read_set_addr_out,
    input  logic [DATA_WIDTH-1:0]     ram_read_data_in,
    output logic [PTR_WIDTH+1:0]      count_out
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [PTR_WIDTH:0]   r_wr_ptr;
    logic [PTR_WIDTH:0]   r_rd_ptr;
    logic                 r_rd_pending;
    logic [PTR_WIDTH+1:0] r_count;

    logic [PTR_WIDTH:0]   w_ram_cnt;
    logic                 w_ram_full;
    logic                 w_ram_empty;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    logic                 w_rd_issue;
    logic [1:0]           w_ob_cnt;
    logic [2:0]           w_ob_demand;
    logic [PTR_WIDTH+1:0] w_count_next;

    assign w_ram_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_ram_full  = (w_ram_cnt == DEPTH_CNT);
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);

    assign enq_ready_out = !w_ram_full;
    assign w_enq_fire    = enq_valid_in & !w_ram_full;

    // Issue a read only if the buffer can still hold it after this cycle's dequeue.
    assign w_ob_demand = {1'b0, w_ob_cnt} + {2'b00, r_rd_pending} - {2'b00, w_deq_fire};
    assign w_rd_issue  = !w_ram_empty && (w_ob_demand < 3'd2);

    assign ram_write_access_en_out = w_enq_fire;
    assign ram_write_en_out        = {WRITE_MASK_LEN{w_enq_fire}};
    assign ram_write_set_addr_out  = r_wr_ptr[PTR_WIDTH-1:0];
    assign ram_write_data_out      = w_enq_fire ? enq_data_in : '0;
    assign ram_read_access_en_out  = w_rd_issue;
    assign ram_read_set_addr_out   = r_rd_ptr[PTR_WIDTH-1:0];

    // Total occupancy (RAM + in-flight read + buffer) tracks every accepted word until it leaves.
    assign w_count_next = r_count + (PTR_WIDTH + 2)'(w_enq_fire) - (PTR_WIDTH + 2)'(w_deq_fire);
    assign count_out    = r_count;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_pending <= 1'b0;
            r_count      <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_pending <= w_rd_issue;
            r_count      <= w_count_next;
        end
    end

    fifo_output_skid_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ob (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .cap_valid_in (r_rd_pending),
        .cap_data_in  (ram_read_data_in),
        .deq_ready_in (deq_ready_in),
        .deq_valid_out(deq_valid_out),
        .deq_data_out (deq_data_out),
        .deq_fire_out (w_deq_fire),
        .ob_cnt_out   (w_ob_cnt)
    );

endmodule

// File: doc/blockram_fifo_ctrl.md
Name: blockram_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the write and read ports of a dual-port blockram (1-cycle read latency, read-first) and presents valid/ready enqueue and dequeue interfaces.
- Sits between a producer and consumer and owns the RAM's pointers and occupancy. It hides RAM read latency with a 2-entry output buffer.
- Sustains 1 enqueue and 1 dequeue per cycle. Total capacity is DEPTH + 2 entries.

Parameters:
- DATA_WIDTH, 64, payload width in bits; multiple of `BYTE_LEN_IN_BITS.
- DEPTH, 64, RAM entries; must be a power of 2, minimum 2.
- PTR_WIDTH, $clog2(DEPTH), RAM address width.
- WRITE_MASK_LEN, DATA_WIDTH / `BYTE_LEN_IN_BITS, RAM byte-enable width.

Ports:
- clk_in  input  1  clock; all state on posedge.
- reset_in  input  1  asynchronous, active-high reset; clears all state.
- enq_valid_in  input  1  producer has data.
- enq_data_in  input  DATA_WIDTH  producer payload.
- enq_ready_out  output  1  controller can accept; enqueue fires on valid & ready.
- deq_valid_out  output  1  head entry available.
- deq_data_out  output  DATA_WIDTH  head payload.
- deq_ready_in  input  1  consumer accepts; dequeue fires on valid & ready.
- ram_write_access_en_out  output  1  RAM write-port enable.
- ram_write_en_out  output  WRITE_MASK_LEN  RAM byte enables.
- ram_write_set_addr_out  output  PTR_WIDTH  RAM write address.
- ram_write_data_out  output  DATA_WIDTH  RAM write data.
- ram_read_access_en_out  output  1  RAM read-port enable.
- ram_read_set_addr_out  output  PTR_WIDTH  RAM read address.
- ram_read_data_in  input  DATA_WIDTH  RAM read data, valid 1 cycle after the read is issued.
- count_out  output  PTR_WIDTH+2  total occupancy (RAM + output buffer).

Behaviour:
- State:
  - wr_ptr and rd_ptr, each PTR_WIDTH+1 bits, with the MSB as the wrap bit.
  - rd_pending flag.
  - Output buffer ob[0..1] with ob_cnt (0..2); ob[0] is the head.
- ram_cnt = wr_ptr − rd_ptr, computed modulo 2^(PTR_WIDTH+1).
- ram_full when ram_cnt == DEPTH. ram_empty when the pointers are equal (including the wrap bit).
- Reset (async): pointers, rd_pending, ob_cnt, count_out and all ram_* enables go to 0. deq_valid_out = 0. Data outputs go to 0.
- enq_ready_out = !ram_full, registered-state only; it has no combinational path from enq_valid_in.
- Enqueue fire:
  - Write is combinational, same cycle: ram_write_access_en_out = 1, ram_write_en_out all ones, addr = wr_ptr[PTR_WIDTH-1:0], data = enq_data_in.
  - wr_ptr increments at the edge.
- Read issue is combinational. Condition: !ram_empty && (ob_cnt + rd_pending − deq_fire) < 2.
  - Drive ram_read_access_en_out with addr = rd_ptr[PTR_WIDTH-1:0].
  - At the edge: rd_ptr increments and rd_pending is set.
- Read-first safety: reads use only registered pointers, so any issued address was written in an earlier cycle. A same-cycle write to the read address cannot occur while !ram_empty, because the FIFO is not full.
- rd_pending set: capture ram_read_data_in at the next edge into ob[ob_cnt − deq_fire]. Clear rd_pending unless a new read was issued.
- deq_valid_out = ob_cnt != 0. deq_data_out = ob[0].
  - On dequeue fire, ob[1] shifts to ob[0].
  - Simultaneous shift and capture must land in the correct slot.
- Latency: enqueue into an empty FIFO at edge T → read issued in cycle T+1 → deq_valid_out high after edge T+2.
- Throughput: continuous enqueue + dequeue gives 1 word/cycle with no bubbles once primed.
- Wrap-around: pointer low bits wrap at DEPTH, and the wrap bit toggles.
- count_out = ram_cnt + ob_cnt + rd_pending, registered.
- Full: enqueue is blocked only by ram_full. Dequeue in the same cycle does not raise enq_ready_out until the next cycle.
- Empty: deq_valid_out = 0. deq_ready_in is ignored.
- Reset mid-operation: everything is discarded. The RAM contents are not cleared. An in-flight read result arriving after reset is ignored (rd_pending = 0).

Decomposition:
- Shared package/header: `BYTE_LEN_IN_BITS (existing parameters.h), plus a new FIFO pointer-width helper macro.
- One natural sub-module: fifo_output_skid_buffer, the 2-entry ob plus its capture/shift logic with valid/ready.

Test Plan:
- Reset then idle → deq_valid_out=0, enq_ready_out=1, count_out=0, ram_read_access_en_out=0.
- Enqueue 0xA5 at edge T, deq_ready_in=1 → deq_valid_out=1 with 0xA5 after edge T+2; count_out returns to 0 one edge after the dequeue.
- Enqueue 66 words 0..65 with deq_ready_in=0 (DEPTH=64) → 64 words in RAM + 2 in ob, enq_ready_out=0 at count_out=66; then drain → 0..65 in order.
- Continuous enqueue/dequeue of 200 incrementing words → in-order output, 1 word/cycle after a 2-cycle prime, pointers wrap 3 times.
- Random deq_ready_in (50%) with full-rate enqueue of 500 words → scoreboard exact order, no drop or duplicate.
- Assert reset_in for 1 cycle while count_out=10 and a read is in flight → all outputs 0 immediately; the next enqueue of 0x3C is the first word out.
